alu_issue: RTL and testbench

Operand-fetch and writeback stage wrapped around the 16-bit combinational `alu`. It accepts register-to-register or register-immediate operations over a valid/ready handshake and owns an 8×16 register file. It drives the ALU's `cs/a/b/cmd` from a registered issue stage, then writes `r` back to the register file and captures `cy/z` into a flags register. Every accepted operation completes in exactly two cycles, with full back-to-back throughput via forwarding.

---
 rtl/alu_issue.sv | 95 +++++++++
 tb/tb_alu_issue.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - operand fetch, issue and writeback around a 16-bit combinational ALU
module alu_issue #(
  parameter int NREG = 8,
  parameter int W    = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         hold,
  input  logic [2:0]   in_cmd,
  input  logic [2:0]   in_rd,
  input  logic [2:0]   in_rs,
  input  logic [2:0]   in_rt,
  input  logic         in_imm_en,
  input  logic [W-1:0] in_imm,
  output logic         alu_cs,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_cmd,
  input  logic [W-1:0] alu_r,
  input  logic         alu_cy,
  input  logic         alu_z,
  output logic         wb_valid,
  output logic [2:0]   wb_rd,
  output logic [W-1:0] wb_data,
  output logic         flag_cy,
  output logic         flag_z,
  input  logic [2:0]   dbg_addr,
  output logic [W-1:0] dbg_data
);

  logic [W-1:0] rf [0:NREG-1];
  logic         ex_valid;
  logic [2:0]   ex_rd;
  logic         accept;
  logic [W-1:0] fwd_rs;
  logic [W-1:0] fwd_rt;

  assign in_ready = ~hold;
  assign accept   = in_valid & ~hold;
  assign alu_cs   = ex_valid;

  // The result still sitting on the ALU outputs is newer than the register file.
  always_comb begin
    fwd_rs = '0;
    fwd_rt = '0;
    if (in_rs != 3'd0)
      fwd_rs = (ex_valid && ex_rd == in_rs) ? alu_r : rf[in_rs];
    if (in_rt != 3'd0)
      fwd_rt = (ex_valid && ex_rd == in_rt) ? alu_r : rf[in_rt];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_rd    <= 3'd0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_cmd  <= 3'd0;
    end else begin
      ex_valid <= accept;
      if (accept) begin
        ex_rd   <= in_rd;
        alu_a   <= fwd_rs;
        alu_b   <= in_imm_en ? in_imm : fwd_rt;
        alu_cmd <= in_cmd;
      end
    end
  end

  // Flags are captured even for rd=0 so compare/test operations remain useful.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= 3'd0;
      wb_data  <= '0;
      flag_cy  <= 1'b0;
      flag_z   <= 1'b0;
    end else begin
      wb_valid <= ex_valid;
      if (ex_valid) begin
        if (ex_rd != 3'd0) rf[ex_rd] <= alu_r;
        wb_rd   <= ex_rd;
        wb_data <= alu_r;
        flag_cy <= alu_cy;
        flag_z  <= alu_z;
      end
    end
  end

  assign dbg_data = (dbg_addr == 3'd0) ? '0 : rf[dbg_addr];

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - scoreboard bench for alu_issue with a behavioural ALU
module tb_alu_issue;

  logic        clk, rst_n, in_valid, in_ready, hold, in_imm_en;
  logic [2:0]  in_cmd, in_rd, in_rs, in_rt;
  logic [15:0] in_imm;
  logic        alu_cs, alu_cy, alu_z;
  logic [15:0] alu_a, alu_b, alu_r;
  logic [2:0]  alu_cmd;
  logic        wb_valid, flag_cy, flag_z;
  logic [2:0]  wb_rd, dbg_addr;
  logic [15:0] wb_data, dbg_data;

  alu_issue #(.NREG(8), .W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .hold(hold),
    .in_cmd(in_cmd), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
    .in_imm_en(in_imm_en), .in_imm(in_imm),
    .alu_cs(alu_cs), .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd),
    .alu_r(alu_r), .alu_cy(alu_cy), .alu_z(alu_z),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flag_cy(flag_cy), .flag_z(flag_z), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Behavioural ALU: 000 add with carry, 001 and
  logic [16:0] alu_sum;
  always_comb begin
    alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
    alu_r   = '0;
    alu_cy  = 1'b0;
    if (alu_cmd == 3'b000) begin
      alu_r  = alu_sum[15:0];
      alu_cy = alu_sum[16];
    end else if (alu_cmd == 3'b001) begin
      alu_r = alu_a & alu_b;
    end
    alu_z = (alu_r == 16'h0000);
  end

  typedef struct { logic [15:0] a; logic [15:0] b; logic [2:0] cmd; } ex_t;
  typedef struct { logic [2:0] rd; logic [15:0] data; logic cy; logic z; } wb_t;

  ex_t ex_q[$];
  wb_t wb_q[$];
  logic [15:0] model_rf [0:7];
  int n_cmp = 0;
  int n_err = 0;
  int wb_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Program-order reference: operands come from the model register file as it
  // stands after every earlier operation.
  task automatic model_push(input logic [2:0] cmd, input logic [2:0] rd, input logic [2:0] rs,
                            input logic [2:0] rt, input logic ie, input logic [15:0] imm);
    ex_t e;
    wb_t w;
    logic [16:0] s;
    e.a   = (rs == 3'd0) ? 16'h0 : model_rf[rs];
    e.b   = ie ? imm : ((rt == 3'd0) ? 16'h0 : model_rf[rt]);
    e.cmd = cmd;
    s = {1'b0, e.a} + {1'b0, e.b};
    w.rd = rd;
    if (cmd == 3'b000) begin
      w.data = s[15:0];
      w.cy   = s[16];
    end else begin
      w.data = e.a & e.b;
      w.cy   = 1'b0;
    end
    w.z = (w.data == 16'h0);
    if (rd != 3'd0) model_rf[rd] = w.data;
    ex_q.push_back(e);
    wb_q.push_back(w);
  endtask

  task automatic op(input logic [2:0] cmd, input logic [2:0] rd, input logic [2:0] rs,
                    input logic [2:0] rt, input logic ie, input logic [15:0] imm,
                    input logic hld, input bit track);
    in_valid = 1'b1; in_cmd = cmd; in_rd = rd; in_rs = rs; in_rt = rt;
    in_imm_en = ie; in_imm = imm; hold = hld;
    if (!hld && track) model_push(cmd, rd, rs, rt, ie, imm);
    @(posedge clk); #1;
    in_valid = 1'b0; hold = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_dbg(input string tag);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] ad;
      ad = i[2:0];
      dbg_addr = ad; #1;
      check($sformatf("%s_dbg%0d", tag, i), {16'h0, dbg_data}, {16'h0, model_rf[ad]});
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) model_rf[i] = 16'h0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (alu_cs) begin
        if (ex_q.size() == 0) check("ex_unexpected", 32'd1, 32'd0);
        else begin
          ex_t e;
          e = ex_q.pop_front();
          check("ex_a", {16'h0, alu_a}, {16'h0, e.a});
          check("ex_b", {16'h0, alu_b}, {16'h0, e.b});
          check("ex_cmd", {29'h0, alu_cmd}, {29'h0, e.cmd});
        end
      end
      if (wb_valid) begin
        wb_cnt++;
        if (wb_q.size() == 0) check("wb_unexpected", 32'd1, 32'd0);
        else begin
          wb_t w;
          w = wb_q.pop_front();
          check("wb_rd", {29'h0, wb_rd}, {29'h0, w.rd});
          check("wb_data", {16'h0, wb_data}, {16'h0, w.data});
          check("flag_cy", {31'h0, flag_cy}, {31'h0, w.cy});
          check("flag_z", {31'h0, flag_z}, {31'h0, w.z});
        end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_cs"}, {31'h0, alu_cs}, 32'h0);
    check({tag, "_a"}, {16'h0, alu_a}, 32'h0);
    check({tag, "_b"}, {16'h0, alu_b}, 32'h0);
    check({tag, "_cmd"}, {29'h0, alu_cmd}, 32'h0);
    check({tag, "_wbv"}, {31'h0, wb_valid}, 32'h0);
    check({tag, "_wbrd"}, {29'h0, wb_rd}, 32'h0);
    check({tag, "_wbdata"}, {16'h0, wb_data}, 32'h0);
    check({tag, "_fcy"}, {31'h0, flag_cy}, 32'h0);
    check({tag, "_fz"}, {31'h0, flag_z}, 32'h0);
    check_dbg(tag);
  endtask

  initial begin
    int cnt0;
    rst_n = 1'b0; in_valid = 1'b0; hold = 1'b0; in_cmd = 3'd0; in_rd = 3'd0;
    in_rs = 3'd0; in_rt = 3'd0; in_imm_en = 1'b0; in_imm = 16'h0; dbg_addr = 3'd0;
    clear_model();
    idle(2);
    check_reset_state("rst0");
    rst_n = 1'b1;
    check("ready_idle", {31'h0, in_ready}, 32'd1);

    // immediate add, forwarding chain, rd=0 compare
    op(3'b000, 3'd1, 3'd0, 3'd0, 1'b1, 16'hFF00, 1'b0, 1'b1);
    op(3'b000, 3'd2, 3'd1, 3'd0, 1'b1, 16'h0100, 1'b0, 1'b1);
    op(3'b000, 3'd3, 3'd2, 3'd2, 1'b0, 16'h0000, 1'b0, 1'b1);
    op(3'b001, 3'd0, 3'd1, 3'd0, 1'b1, 16'hF0F0, 1'b0, 1'b1);
    op(3'b000, 3'd4, 3'd0, 3'd0, 1'b1, 16'h1234, 1'b0, 1'b1);
    op(3'b000, 3'd5, 3'd4, 3'd4, 1'b0, 16'h0000, 1'b0, 1'b1);
    op(3'b000, 3'd6, 3'd0, 3'd5, 1'b0, 16'h0000, 1'b0, 1'b1);
    idle(3);
    check("dbg_r1", {16'h0, model_rf[1]}, 32'hFF00);
    check_dbg("dir");

    // hold with an operation offered
    op(3'b000, 3'd7, 3'd6, 3'd0, 1'b1, 16'h0001, 1'b0, 1'b1);
    cnt0 = wb_cnt;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_cmd = 3'b000; in_rd = 3'd1; in_rs = 3'd7; in_rt = 3'd0;
      in_imm_en = 1'b1; in_imm = 16'h0010; hold = 1'b1; #1;
      check("hold_ready", {31'h0, in_ready}, 32'd0);
      if (i > 0) check("hold_cs", {31'h0, alu_cs}, 32'd0);
      @(posedge clk); #1;
    end
    op(3'b000, 3'd1, 3'd7, 3'd0, 1'b1, 16'h0010, 1'b0, 1'b1);
    idle(3);
    check("hold_wbcnt", wb_cnt - cnt0, 32'd2);

    // async reset while an operation sits in EX
    cnt0 = wb_cnt;
    op(3'b000, 3'd3, 3'd0, 3'd0, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    rst_n = 1'b0;
    clear_model();
    ex_q.delete(); wb_q.delete();
    idle(2);
    rst_n = 1'b1;
    idle(2);
    check("midop_wbcnt", wb_cnt - cnt0, 32'd0);
    check_dbg("midop");

    // random burst with source-held stalls
    for (int n = 0; n < 80; n++) begin
      logic [2:0] c, d, s, t;
      logic ie;
      logic [15:0] im;
      c = 3'($urandom_range(0, 1)); d = 3'($urandom_range(0, 7));
      s = 3'($urandom_range(0, 7)); t = 3'($urandom_range(0, 7));
      ie = 1'($urandom_range(0, 1)); im = 16'($urandom);
      while ($urandom_range(0, 3) == 0) op(c, d, s, t, ie, im, 1'b1, 1'b1);
      op(c, d, s, t, ie, im, 1'b0, 1'b1);
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    idle(3);
    check_dbg("burst");
    check("drain_ex", ex_q.size(), 32'd0);
    check("drain_wb", wb_q.size(), 32'd0);

    // reset pulse mid-run, then confirm silence after release
    cnt0 = wb_cnt;
    rst_n = 1'b0;
    clear_model();
    #3;
    check_reset_state("rst1");
    idle(1);
    rst_n = 1'b1;
    idle(3);
    check("rst1_nowb", wb_cnt - cnt0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
